// File: rtl/fp_pkg.sv
// Shared definitions for the multi-cycle floating-point add/subtract unit.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  // guard, round and sticky bits carried below the significand LSB
  localparam int GRS_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    ROUND
  } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input returns IN_W.
module fp_lzc #(
  parameter int IN_W  = 25,
  parameter int CNT_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]  din,
  output logic [CNT_W-1:0] cnt
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CNT_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (din[i]) cnt = CNT_W'(IN_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_fsm.sv
// Sequential IEEE-754-style add/subtract: one FSM state per arithmetic step,
// fixed five-cycle latency, flush-to-zero, round to nearest even.
module fp_addsub_fsm
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   r_i,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   r_o,
  output logic                   busy
);

  localparam int W        = 1 + EXP_W + MAN_W;
  localparam int SIG_W    = MAN_W + 1;
  localparam int EXT_W    = SIG_W + GRS_W;
  localparam int SUM_W    = EXT_W + 1;
  localparam int EXS_W    = EXP_W + 2;
  localparam int LZC_IN_W = MAN_W + 2;
  localparam int LZC_W    = $clog2(LZC_IN_W + 1);

  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic [W-1:0]            QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EXS_W-1:0] EXS_ZERO = '0;
  localparam logic signed [EXS_W-1:0] EXS_ONE  = EXS_W'(1);
  localparam logic signed [EXS_W-1:0] EXS_MAX  = EXS_W'((1 << EXP_W) - 1);

  function automatic logic [W-1:0] pack_inf(input logic s);
    return {s, EXP_ONES, {MAN_W{1'b0}}};
  endfunction

  // e_pre is the normalised exponent (underflow test), e_post includes the rounding carry.
  function automatic logic [W-1:0] saturate(input logic s,
                                            input logic signed [EXS_W-1:0] e_pre,
                                            input logic signed [EXS_W-1:0] e_post,
                                            input logic [MAN_W-1:0] m);
    if (e_pre <= EXS_ZERO) return {s, {(W-1){1'b0}}};
    if (e_post >= EXS_MAX) return pack_inf(s);
    return {s, e_post[EXP_W-1:0], m};
  endfunction

  function automatic logic [W-1:0] round_pack(input logic s,
                                              input logic signed [EXS_W-1:0] e,
                                              input logic [EXT_W-1:0] sig);
    logic [SIG_W-1:0]        mant;
    logic                    up;
    logic [SIG_W:0]          mr;
    logic signed [EXS_W-1:0] er;
    logic [MAN_W-1:0]        m;
    mant = sig[EXT_W-1:GRS_W];
    up   = sig[GRS_W-1] & ((|sig[GRS_W-2:0]) | mant[0]);
    mr   = {1'b0, mant} + {{SIG_W{1'b0}}, up};
    er   = e + $signed({{(EXS_W-1){1'b0}}, mr[SIG_W]});
    m    = mr[SIG_W] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    return saturate(s, e, er, m);
  endfunction

  state_t state, state_nx;
  logic   accept;

  logic [W-1:0]            a_p0, b_p0;
  logic                    op_p0;
  logic                    sign_mx_p1, eff_sub_p1, spec_vld_p1;
  logic [EXP_W-1:0]        exp_mx_p1, exp_diff_p1;
  logic [SIG_W-1:0]        sig_mx_p1, sig_mn_p1;
  logic [W-1:0]            spec_res_p1;
  logic [EXT_W-1:0]        aln_mn_p2;
  logic [SUM_W-1:0]        sum_p3;
  logic [EXT_W-1:0]        nsig_p4;
  logic signed [EXS_W-1:0] nexp_p4;
  logic                    zero_p4, sign_p4;

  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        ma, mb;
  logic                    sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
  logic [W-2:0]            mag_a, mag_b;
  logic [SIG_W-1:0]        sig_a, sig_b;
  logic                    sign_mx_d, eff_sub_d, spec_vld_d;
  logic [EXP_W-1:0]        exp_mx_d, exp_diff_d;
  logic [SIG_W-1:0]        sig_mx_d, sig_mn_d;
  logic [W-1:0]            spec_res_d;
  logic [EXT_W-1:0]        ext_mn, shifted, lost, aln_d;
  logic [SUM_W-1:0]        ext_mx, sum_d;
  logic [LZC_W-1:0]        lzc_cnt;
  logic [EXT_W-1:0]        nsig_d;
  logic signed [EXS_W-1:0] exp_ext, nexp_d;
  logic                    zero_d, sign_d;
  logic [W-1:0]            res_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE) || r_o;
    accept   = (state == IDLE) && r_i && !r_o;
    unique case (state)
      IDLE:    if (accept) state_nx = UNPACK;
      UNPACK:  state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- UNPACK: classify, flush subnormals, order by magnitude ----
  always_comb begin
    ea     = a_p0[W-2:MAN_W];
    ma     = a_p0[MAN_W-1:0];
    eb     = b_p0[W-2:MAN_W];
    mb     = b_p0[MAN_W-1:0];
    sa     = a_p0[W-1];
    sb     = b_p0[W-1] ^ op_p0;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (ea == EXP_ONES) && (ma != '0);
    b_nan  = (eb == EXP_ONES) && (mb != '0);
    a_inf  = (ea == EXP_ONES) && (ma == '0);
    b_inf  = (eb == EXP_ONES) && (mb == '0);
    mag_a  = a_zero ? '0 : {ea, ma};
    mag_b  = b_zero ? '0 : {eb, mb};
    sig_a  = a_zero ? '0 : {1'b1, ma};
    sig_b  = b_zero ? '0 : {1'b1, mb};
    swap   = (mag_b > mag_a);

    spec_vld_d = a_nan || b_nan || a_inf || b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_res_d = QNAN;
    else if (a_inf)                                       spec_res_d = pack_inf(sa);
    else                                                  spec_res_d = pack_inf(sb);

    sign_mx_d  = swap ? sb : sa;
    eff_sub_d  = sa ^ sb;
    exp_mx_d   = swap ? mag_b[W-2:MAN_W] : mag_a[W-2:MAN_W];
    exp_diff_d = swap ? (mag_b[W-2:MAN_W] - mag_a[W-2:MAN_W])
                      : (mag_a[W-2:MAN_W] - mag_b[W-2:MAN_W]);
    sig_mx_d   = swap ? sig_b : sig_a;
    sig_mn_d   = swap ? sig_a : sig_b;
  end

  // ---- ALIGN: right-shift smaller significand, OR shifted-out bits into sticky ----
  always_comb begin
    ext_mn  = {sig_mn_p1, {GRS_W{1'b0}}};
    shifted = '0;
    lost    = '0;
    if (32'(exp_diff_p1) >= EXT_W - 1) begin
      aln_d = {{(EXT_W-1){1'b0}}, |sig_mn_p1};
    end else begin
      shifted = ext_mn >> exp_diff_p1;
      lost    = ext_mn & ~({EXT_W{1'b1}} << exp_diff_p1);
      aln_d   = {shifted[EXT_W-1:1], shifted[0] | (|lost)};
    end
  end

  // ---- ADD ----
  always_comb begin
    ext_mx = {1'b0, sig_mx_p1, {GRS_W{1'b0}}};
    sum_d  = eff_sub_p1 ? (ext_mx - {1'b0, aln_mn_p2}) : (ext_mx + {1'b0, aln_mn_p2});
  end

  // ---- NORM: carry right-shift or leading-zero left-shift ----
  fp_lzc #(
    .IN_W  (LZC_IN_W),
    .CNT_W (LZC_W)
  ) u_lzc (
    .din (sum_p3[EXT_W-1:GRS_W-1]),
    .cnt (lzc_cnt)
  );

  always_comb begin
    zero_d  = (sum_p3 == '0);
    sign_d  = (zero_d && eff_sub_p1) ? 1'b0 : sign_mx_p1;
    exp_ext = $signed({2'b00, exp_mx_p1});
    if (sum_p3[SUM_W-1]) begin
      nsig_d = {sum_p3[SUM_W-1:2], sum_p3[1] | sum_p3[0]};
      nexp_d = exp_ext + EXS_ONE;
    end else begin
      nsig_d = sum_p3[EXT_W-1:0] << lzc_cnt;
      nexp_d = exp_ext - $signed({{(EXS_W-LZC_W){1'b0}}, lzc_cnt});
    end
  end

  // ---- ROUND: specials bypass the arithmetic path ----
  always_comb begin
    if (spec_vld_p1)  res_d = spec_res_p1;
    else if (zero_p4) res_d = {sign_p4, {(W-1){1'b0}}};
    else              res_d = round_pack(sign_p4, nexp_p4, nsig_p4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0        <= '0;
      b_p0        <= '0;
      op_p0       <= 1'b0;
      sign_mx_p1  <= 1'b0;
      eff_sub_p1  <= 1'b0;
      spec_vld_p1 <= 1'b0;
      exp_mx_p1   <= '0;
      exp_diff_p1 <= '0;
      sig_mx_p1   <= '0;
      sig_mn_p1   <= '0;
      spec_res_p1 <= '0;
      aln_mn_p2   <= '0;
      sum_p3      <= '0;
      nsig_p4     <= '0;
      nexp_p4     <= '0;
      zero_p4     <= 1'b0;
      sign_p4     <= 1'b0;
      res         <= '0;
      r_o         <= 1'b0;
    end else begin
      r_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_p0  <= a;
            b_p0  <= b;
            op_p0 <= op;
          end
        end
        UNPACK: begin
          sign_mx_p1  <= sign_mx_d;
          eff_sub_p1  <= eff_sub_d;
          spec_vld_p1 <= spec_vld_d;
          exp_mx_p1   <= exp_mx_d;
          exp_diff_p1 <= exp_diff_d;
          sig_mx_p1   <= sig_mx_d;
          sig_mn_p1   <= sig_mn_d;
          spec_res_p1 <= spec_res_d;
        end
        ALIGN: aln_mn_p2 <= aln_d;
        ADD:   sum_p3    <= sum_d;
        NORM: begin
          nsig_p4 <= nsig_d;
          nexp_p4 <= nexp_d;
          zero_p4 <= zero_d;
          sign_p4 <= sign_d;
        end
        ROUND: begin
          res <= res_d;
          r_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_fsm.sv
// Bench for fp_addsub_fsm: vector table through a result scoreboard, plus
// hand-written latency, overlap and reset-abort sequences.
module tb_fp_addsub_fsm;

  logic        clk = 1'b0;
  logic        rst, r_i, op;
  logic [31:0] a, b, res;
  logic        r_o, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          tag;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[19];

  fp_addsub_fsm dut (
    .clk  (clk),
    .rst  (rst),
    .r_i  (r_i),
    .op   (op),
    .a    (a),
    .b    (b),
    .res  (res),
    .r_o  (r_o),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every completion pops one expectation.
  always @(posedge clk) begin
    #1;
    if (r_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_r_o: got res %h, required no completion", res);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check($sformatf("res_tag%0d", e.tag), res, e.exp);
      end
    end
  end

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                       input logic [31:0] vexp, input int tag);
    @(negedge clk);
    a = va; b = vb; op = vop; r_i = 1'b1;
    @(posedge clk);
    sb_q.push_back('{exp: vexp, tag: tag});
    @(negedge clk);
    r_i = 1'b0;
    a = $urandom; b = $urandom; op = 1'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still %b after 20 cycles, required 0", name, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    vecs[1]  = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000};
    vecs[2]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
    vecs[4]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    vecs[6]  = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000};
    vecs[7]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    vecs[8]  = '{32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
    vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000};
    vecs[11] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000};
    vecs[12] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[13] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000};
    vecs[14] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};
    vecs[15] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000};
    vecs[16] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000};
    vecs[17] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};
    vecs[18] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000};

    rst = 1'b1; r_i = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res", res, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_r_o", 32'(r_o), 32'd0);
    rst = 1'b0;

    // Latency: accept edge is cycle 0, r_o in cycle 5, busy in cycles 0..5.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; op = 1'b0; r_i = 1'b1;
    @(posedge clk);
    sb_q.push_back('{exp: 32'h40400000, tag: 100});
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      if (k == 0) begin
        r_i = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678; op = 1'b1;
      end
      check($sformatf("lat_busy_c%0d", k), 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
      check($sformatf("lat_r_o_c%0d", k), 32'(r_o), (k == 5) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, i);
      wait_idle($sformatf("vec%0d", i));
    end

    // Second request in cycle 2 must be ignored.
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h3FC00000; op = 1'b0; r_i = 1'b1;
    @(posedge clk);
    sb_q.push_back('{exp: 32'h40400000, tag: 200});
    #1 r_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b1; r_i = 1'b1;
    @(posedge clk);
    #1 r_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (r_o) cnt++;
    end
    check("overlap_r_o_count", 32'(cnt), 32'd1);
    wait_idle("overlap");

    // Reset in cycle 3 aborts; new request accepted right after.
    @(negedge clk);
    a = 32'h40000000; b = 32'h3F800000; op = 1'b0; r_i = 1'b1;
    @(posedge clk);
    #1 r_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_res", res, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_r_o", 32'(r_o), 32'd0);
    rst = 1'b0;
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; r_i = 1'b1;
    @(posedge clk);
    sb_q.push_back('{exp: 32'h40000000, tag: 300});
    #1;
    r_i = 1'b0;
    check("post_rst_accept_busy", 32'(busy), 32'd1);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (r_o) cnt++;
    end
    check("abort_no_r_o", 32'(cnt), 32'd0);
    wait_idle("post_rst");

    // Reset wins over a simultaneous request.
    @(negedge clk);
    rst = 1'b1; r_i = 1'b1;
    @(posedge clk);
    #1;
    check("rst_priority_busy", 32'(busy), 32'd0);
    rst = 1'b0; r_i = 1'b0;

    repeat (10) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_fsm.md
FP_ADDSUB_FSM -- requirements
Module: fp_addsub_fsm

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; W = 1+EXP_W+MAN_W (32 at defaults).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port r_i  in  1  request; operands accepted when r_i=1 and busy=0.
REQ-006 SHALL have port op  in  1  0 = a+b, 1 = a-b.
REQ-007 SHALL have port a  in  W  IEEE-754-style operand A.
REQ-008 SHALL have port b  in  W  IEEE-754-style operand B.
REQ-009 SHALL have port res  out  W  result; holds last value until next completion.
REQ-010 SHALL have port r_o  out  1  one-cycle done pulse, res valid in the same cycle.
REQ-011 SHALL have port busy  out  1  high from the accept cycle until the r_o cycle inclusive.

Function
REQ-012 SHALL register a, b and op on accept; later input changes SHALL NOT affect the operation.
REQ-013 SHALL use FSM states IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> IDLE, one cycle each.
REQ-014 SHALL assert r_o exactly 5 cycles after the accept edge (accept edge = cycle 0, r_o high in cycle 5); latency is independent of operand values.
REQ-015 SHALL ignore r_i while busy=1; r_i in the r_o cycle is also ignored; the earliest new accept is the cycle after r_o.
REQ-016 UNPACK: effective sign of B = b[W-1]^op; SHALL order the operands by magnitude (exponent, then mantissa) so that |mx| >= |mn|.
REQ-017 ALIGN: SHALL shift mn's significand right by the exponent difference, keeping guard, round and sticky bits; a difference >= MAN_W+3 SHALL yield only sticky.
REQ-018 ADD: SHALL add significands on equal effective signs, otherwise subtract (mx-mn); the result sign is mx's sign.
REQ-019 NORM: SHALL right-shift by 1 on carry-out (exp+1), otherwise left-shift by the leading-zero count (exp-lzc), all in one cycle.
REQ-020 ROUND: SHALL round to nearest, ties to even; a mantissa carry from rounding SHALL increment the exponent.
REQ-021 SHALL flush subnormal inputs (exp=0) to signed zero; an exponent result <= 0 SHALL produce a zero with the result sign.
REQ-022 SHALL produce exponent all-ones with mantissa 0 (signed infinity) when the exponent overflows.
REQ-023 SHALL produce signed infinity when an infinity operand is combined with a finite operand.
REQ-024 SHALL produce canonical NaN {0, all-ones exp, MSB-set mantissa} (0x7FC00000 at defaults) for any NaN input and for inf - inf of effective opposite signs.
REQ-025 SHALL produce an exact cancellation (x - x) as +0; (-0)+(-0) SHALL produce -0.
REQ-026 SHALL encode specials in UNPACK and bypass the arithmetic result while keeping the fixed 5-cycle latency.

Reset
REQ-027 rst=1 at a clock edge SHALL set the state to IDLE with res=0, r_o=0, busy=0, and clear all internal registers.
REQ-028 rst during an operation SHALL abort it; no r_o SHALL follow for that operation.
REQ-029 rst SHALL take priority over a simultaneous r_i.

Structure
REQ-030 SHALL keep the state enum, default EXP_W/MAN_W, and the GRS width constant in shared package fp_pkg.
REQ-031 SHALL implement the leading-zero count as parametrised sub-module fp_lzc (input MAN_W+2 bits, output count).

Verification
REQ-032 Bench SHALL check: a=0x3F800000, b=0x40000000, op=0 -> res=0x40400000, r_o in cycle 5, busy high in cycles 0-5.
REQ-033 Bench SHALL check: a=0x40400000, b=0x40400000, op=1 -> res=0x00000000; a=0x7F800000, b=0xFF800000, op=0 -> res=0x7FC00000.
REQ-034 Bench SHALL check: a=0x3F800000, b=0x33800000 -> 0x3F800000 (tie to even); b=0x33800001 -> 0x3F800001.
REQ-035 Bench SHALL check: a=b=0x7F7FFFFF, op=0 -> res=0x7F800000; a=0x00400000 (subnormal), b=0x3F800000 -> 0x3F800000.
REQ-036 Bench SHALL check: second r_i pulse in cycle 2 ignored, with exactly one r_o; rst asserted in cycle 3 -> no r_o, res=0, and a new request is accepted the cycle after rst deasserts.
